// File: rtl/cover_pkg.sv
// Shared types and constants for the toggle-cover report scheduler.
package cover_pkg;

  typedef logic [63:0] cover_index_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFlush
  } cover_state_e;

  localparam int unsigned COVER_TOTAL_DEFAULT = 38253;

  // Width of a pointer into an n-entry vector, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cover_rr_pick.sv
// Round-robin first-set picker: lowest set bit of req at or after ptr, wrapping to 0.
module cover_rr_pick
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH = 29
) (
  input  logic [WIDTH-1:0]            req,
  input  logic [ptr_width(WIDTH)-1:0] ptr,
  output logic [ptr_width(WIDTH)-1:0] sel,
  output logic                        any
);

  localparam int unsigned PtrW = ptr_width(WIDTH);

  int unsigned      sum;
  logic [PtrW-1:0]  idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    sum = 0;
    idx = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      sum = 32'(ptr) + k;
      if (sum >= WIDTH) sum = sum - WIDTH;
      idx = PtrW'(sum);
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/cover_toggle_sched.sv
// Collects sticky toggle-cover hits and reports them one at a time, round-robin, over a
// valid/ready port. Define COVER_DEDUP_EN to report each point at most once after reset.
module cover_toggle_sched
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH       = 29,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = COVER_TOTAL_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         enable,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output cover_index_t                 out_index,
  output logic [$clog2(WIDTH+1)-1:0]   pending_cnt,
  output logic                         flush_done
);

  localparam int unsigned PtrW = ptr_width(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (longint'(COVER_INDEX) + longint'(WIDTH) > longint'(COVER_TOTAL)) begin : g_range_check
    $error("cover_toggle_sched: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d, sel_q, sel_d, pick_sel;
  logic             pick_any, handshake;
  logic             out_valid_q, out_valid_d;
  cover_index_t     out_index_q, out_index_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rehit_q, rehit_d;
  cover_state_e     state_q, state_d;

  assign handshake = out_valid_q & out_ready;

  cover_rr_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .req (pending_q),
    .ptr (rr_ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

`ifdef COVER_DEDUP_EN
  logic [WIDTH-1:0] covered_q, covered_d;

  assign covered_d = covered_q | clr_mask;
  assign set_mask  = enable ? (valid & ~covered_d) : '0;
  assign rehit_d   = 1'b0;

  always_ff @(posedge clock) begin
    if (!reset) covered_q <= '0;
    else        covered_q <= covered_d;
  end
`else
  assign set_mask = enable ? valid : '0;
  // A hit on the point already on offer is a new hit, so it must survive the handshake.
  assign rehit_d  = out_valid_q && !handshake && (rehit_q || set_mask[sel_q]);
`endif

  always_comb begin
    clr_mask = '0;
    if (handshake && !rehit_q) clr_mask[sel_q] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    cnt_d     = CntW'($countones(pending_d));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (handshake) begin
      out_valid_d = 1'b0;
      rr_ptr_d    = (sel_q == PtrW'(WIDTH - 1)) ? '0 : sel_q + 1'b1;
    end else if (!out_valid_q && pick_any) begin
      out_valid_d = 1'b1;
      sel_d       = pick_sel;
      out_index_d = cover_index_t'(COVER_INDEX) + cover_index_t'(pick_sel);
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (flush)                 state_d = StFlush;
        else if (pending_q != '0)  state_d = StBusy;
      end
      StBusy: begin
        if (flush)                                    state_d = StFlush;
        else if (pending_q == '0 && !out_valid_q)     state_d = StIdle;
      end
      StFlush: begin
        if (pending_q == '0 && !out_valid_q) begin
          state_d    = StIdle;
          flush_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      cnt_q       <= '0;
      rehit_q     <= 1'b0;
      state_q     <= StIdle;
    end else begin
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      cnt_q       <= cnt_d;
      rehit_q     <= rehit_d;
      state_q     <= state_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Bench for cover_toggle_sched (WIDTH=29, COVER_INDEX=100): reference model plus directed scenarios.
module tb_cover_toggle_sched;

  localparam int W    = 29;
  localparam int BASE = 100;

  logic          clock = 1'b0;
  logic          reset, enable, flush, out_ready;
  logic [W-1:0]  valid;
  logic          out_valid, flush_done;
  logic [63:0]   out_index;
  logic [4:0]    pending_cnt;

  int checks = 0;
  int errors = 0;
  longint unsigned rep_log[$];

  // Reference model state: the set of outstanding points and the point on offer.
  bit [W-1:0] m_pend = '0;
  bit [W-1:0] m_cov  = '0;
  int         m_ptr  = 0;
  int         m_sel  = 0;
  bit         m_ov   = 1'b0;
  bit         m_again = 1'b0;
  bit         m_flushing = 1'b0;
  longint unsigned m_idx = 0;

  cover_toggle_sched #(
    .WIDTH       (W),
    .COVER_INDEX (BASE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .enable      (enable),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .pending_cnt (pending_cnt),
    .flush_done  (flush_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_step();
    bit [W-1:0] old, hits;
    if (!reset) begin
      m_pend = '0; m_cov = '0; m_ptr = 0; m_sel = 0; m_ov = 0;
      m_again = 0; m_flushing = 0; m_idx = 0;
      return;
    end
    old = m_pend;
    if (m_flushing) begin
      if (old == 0 && !m_ov) m_flushing = 0;
    end else if (flush) begin
      m_flushing = 1;
    end
    hits = enable ? valid : '0;
    if (m_ov && out_ready) begin
`ifdef COVER_DEDUP_EN
      m_cov[m_sel] = 1'b1;
`endif
      if (!m_again) m_pend[m_sel] = 1'b0;
      m_again = 0;
      m_ptr = (m_sel + 1) % W;
      m_ov = 0;
    end else if (m_ov) begin
`ifndef COVER_DEDUP_EN
      if (hits[m_sel]) m_again = 1;
`endif
    end else if (old != 0) begin
      for (int k = 0; k < W; k++) begin
        int j;
        j = (m_ptr + k) % W;
        if (old[j]) begin
          m_sel = j;
          break;
        end
      end
      m_ov = 1;
      m_idx = BASE + m_sel;
    end
`ifdef COVER_DEDUP_EN
    hits = hits & ~m_cov;
`endif
    m_pend = m_pend | hits;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Every cycle: DUT against the model, and log each accepted report.
  initial forever begin
    @(negedge clock);
    chk("model out_valid", 64'(out_valid), 64'(m_ov));
    chk("model out_index", out_index, m_idx);
    chk("model pending_cnt", 64'(pending_cnt), 64'($countones(m_pend)));
    chk("model flush_done", 64'(flush_done), 64'(m_flushing && m_pend == 0 && !m_ov));
    if (out_valid === 1'b1 && out_ready === 1'b1) rep_log.push_back(out_index);
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int n107;
    int pulses;
    reset = 1'b0; enable = 1'b1; flush = 1'b0; out_ready = 1'b1; valid = '0;
    step(); step();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_index", out_index, 64'd0);
    chk("reset pending_cnt", 64'(pending_cnt), 64'd0);
    chk("reset flush_done", 64'(flush_done), 64'd0);
    reset = 1'b1;
    step();

    // Scenario 1: single hit on bit 3, offered two cycles later.
    rep_log.delete();
    valid = W'(1) << 3;
    step();
    valid = '0;
    chk("s1 out_valid after 1", 64'(out_valid), 64'd0);
    chk("s1 pending_cnt after 1", 64'(pending_cnt), 64'd1);
    step();
    chk("s1 out_valid after 2", 64'(out_valid), 64'd1);
    chk("s1 out_index", out_index, 64'd103);
    step();
    chk("s1 out_valid drop", 64'(out_valid), 64'd0);
    chk("s1 pending_cnt drained", 64'(pending_cnt), 64'd0);
    step();
    chk("s1 report count", 64'(rep_log.size()), 64'd1);
    if (rep_log.size() > 0) chk("s1 report", rep_log[0], 64'd103);

    // Scenario 2: bring the pointer to 6, then hit 28, 0 and 5 together.
    valid = W'(1) << 5;
    step();
    valid = '0;
    repeat (4) step();
    rep_log.delete();
    valid = (W'(1) << 28) | W'(1) | (W'(1) << 5);
    step();
    valid = '0;
    repeat (12) step();
`ifdef COVER_DEDUP_EN
    chk("s2 report count", 64'(rep_log.size()), 64'd2);
`else
    chk("s2 report count", 64'(rep_log.size()), 64'd3);
    if (rep_log.size() > 2) chk("s2 report 2", rep_log[2], 64'd105);
`endif
    if (rep_log.size() > 1) begin
      chk("s2 report 0", rep_log[0], 64'd128);
      chk("s2 report 1", rep_log[1], 64'd100);
    end

    // Scenario 3: stalled sink holding 107, with bit 7 re-hit during the stall.
    rep_log.delete();
    out_ready = 1'b0;
    valid = W'(1) << 7;
    step();
    valid = '0;
    step();
    chk("s3 offered", 64'(out_valid), 64'd1);
    chk("s3 index", out_index, 64'd107);
    for (int i = 0; i < 10; i++) begin
      valid = (i == 3) ? (W'(1) << 7) : '0;
      step();
      chk("s3 hold valid", 64'(out_valid), 64'd1);
      chk("s3 hold index", out_index, 64'd107);
      chk("s3 hold pending_cnt", 64'(pending_cnt), 64'd1);
    end
    valid = '0;
    out_ready = 1'b1;
    repeat (10) step();
    n107 = 0;
    foreach (rep_log[i]) if (rep_log[i] == 64'd107) n107++;
`ifdef COVER_DEDUP_EN
    chk("s3 reports of 107", 64'(n107), 64'd1);
`else
    chk("s3 reports of 107", 64'(n107), 64'd2);
`endif
    chk("s3 pending_cnt end", 64'(pending_cnt), 64'd0);

    // Scenario 4: four pending points, then a flush drains them.
    out_ready = 1'b0;
    valid = W'(32'h3C00);
    step();
    valid = '0;
    step(); step();
    chk("s4 pending_cnt", 64'(pending_cnt), 64'd4);
    chk("s4 offered", 64'(out_valid), 64'd1);
    rep_log.delete();
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (flush_done === 1'b1) begin
        pulses++;
        chk("s4 done pending_cnt", 64'(pending_cnt), 64'd0);
        chk("s4 done out_valid", 64'(out_valid), 64'd0);
        chk("s4 done reports", 64'(rep_log.size()), 64'd4);
      end
      step();
    end
    chk("s4 flush_done pulses", 64'(pulses), 64'd1);
    if (rep_log.size() == 4) begin
      chk("s4 first report", rep_log[0], 64'd110);
      chk("s4 last report", rep_log[3], 64'd113);
    end

    // Scenario 5: reset while a report is offered and six points are pending.
    out_ready = 1'b0;
    valid = W'(32'hFC000);
    step();
    valid = '0;
    step(); step();
    chk("s5 offered", 64'(out_valid), 64'd1);
    chk("s5 index", out_index, 64'd114);
    chk("s5 pending_cnt", 64'(pending_cnt), 64'd6);
    reset = 1'b0;
    valid = '1;
    step();
    chk("s5 rst out_valid", 64'(out_valid), 64'd0);
    chk("s5 rst out_index", out_index, 64'd0);
    chk("s5 rst pending_cnt", 64'(pending_cnt), 64'd0);
    chk("s5 rst flush_done", 64'(flush_done), 64'd0);
    reset = 1'b1;
    valid = '0;
    out_ready = 1'b1;
    rep_log.delete();
    repeat (10) begin
      step();
      chk("s5 quiet out_valid", 64'(out_valid), 64'd0);
    end
    chk("s5 no reports", 64'(rep_log.size()), 64'd0);

    // Scenario 6: hits ignored while capture is disabled.
    enable = 1'b0;
    valid = '1;
    repeat (5) begin
      step();
      chk("s6 pending_cnt", 64'(pending_cnt), 64'd0);
      chk("s6 out_valid", 64'(out_valid), 64'd0);
    end
    valid = '0;
    enable = 1'b1;
    repeat (3) begin
      step();
      chk("s6 after pending_cnt", 64'(pending_cnt), 64'd0);
      chk("s6 after out_valid", 64'(out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cover_toggle_sched.md
COVER_TOGGLE_SCHED -- requirements
Module: cover_toggle_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 29: number of toggle cover points served.
REQ-002 SHALL have parameter COVER_INDEX, default 0: global index of point 0.
REQ-003 SHALL have parameter COVER_TOTAL, default 38253: global cover-point count, used for range checking.
REQ-004 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous active-low reset (0 = reset).
REQ-006 SHALL have port valid, input, WIDTH: per-point toggle hit for this cycle.
REQ-007 SHALL have port enable, input, 1: capture enable; when 0, valid is ignored.
REQ-008 SHALL have port flush, input, 1: one-cycle request to drain all pending hits.
REQ-009 SHALL have port out_valid, output, 1: a report is offered.
REQ-010 SHALL have port out_ready, input, 1: the sink accepts the report.
REQ-011 SHALL have port out_index, output, 64: global cover index of the offered report.
REQ-012 SHALL have port pending_cnt, output, clog2(WIDTH+1): popcount of pending hits.
REQ-013 SHALL have port flush_done, output, 1: one-cycle pulse when a flush completes.

Function
REQ-014 SHALL keep sticky register pending[WIDTH]; pending[i] is set at the next edge when valid[i] and enable are both 1; repeat hits merge into the same bit.
REQ-015 SHALL have states IDLE, BUSY and FLUSH; the state register is internal.
REQ-016 SHALL make these state transitions:
  - IDLE->BUSY when pending!=0.
  - BUSY->IDLE when pending==0 and out_valid==0.
  - IDLE or BUSY->FLUSH when flush==1.
  - FLUSH->IDLE when pending==0 and out_valid==0; this transition pulses flush_done in the same cycle.
REQ-017 SHALL, when out_valid==0 and pending!=0 in BUSY or FLUSH, select sel = the first set bit at or after rr_ptr, wrapping WIDTH-1 to 0. At the next edge it SHALL assert out_valid and set out_index = COVER_INDEX + sel, zero-extended to 64 bits.
REQ-018 SHALL hold out_valid and out_index stable while out_ready==0.
REQ-019 SHALL, on out_valid && out_ready, clear pending[sel] and set rr_ptr = (sel+1) mod WIDTH. It SHALL deassert out_valid or offer the next selection at the following edge, giving a maximum throughput of one report per 2 cycles.
REQ-020 SHALL give priority to set over clear: if valid[sel] hits in the same cycle as the handshake for sel, pending[sel] stays 1.
REQ-021 SHALL have a minimum latency of 2 cycles from valid[i] to out_valid with idle sink and empty pending.
REQ-022 SHALL register pending_cnt; it reflects pending after each edge.
REQ-023 SHALL keep capturing hits during FLUSH; flush_done occurs only once every hit is reported.
REQ-024 SHALL ignore flush while already in FLUSH.
REQ-025 SHALL flag an error in simulation (non-synthesis check) if COVER_INDEX+WIDTH > COVER_TOTAL.

Reset
REQ-026 SHALL, while reset==0 at an edge, clear pending and rr_ptr, and force out_valid=0, out_index=0, pending_cnt=0, flush_done=0 and state=IDLE.
REQ-027 SHALL, on reset mid-operation, drop any offered report and all pending hits without a handshake; valid is ignored in reset cycles.

Configuration
REQ-028 SHALL support macro COVER_DEDUP_EN. When defined, a covered[WIDTH] register is set on each handshake for sel, reset to 0, and hits on covered points are never re-pended. Each point is then reported at most once after reset, and REQ-020 does not re-pend a covered point.
REQ-029 SHALL, when COVER_DEDUP_EN is undefined, omit the covered register; every non-merged hit is reported.

Structure
REQ-030 SHALL take from shared package cover_pkg:
  - cover_index_t (64-bit).
  - the state enum (IDLE/BUSY/FLUSH).
  - COVER_TOTAL_DEFAULT = 38253.
REQ-031 SHALL place round-robin first-set selection in sub-module cover_rr_pick, with inputs req[WIDTH] and ptr, and outputs sel and any.

Verification (WIDTH=29, COVER_INDEX=100)
REQ-032 SHALL cover scenario 1: valid=bit 3 for 1 cycle, out_ready=1 -> out_valid exactly 2 cycles later with out_index=103; then IDLE, pending_cnt=0.
REQ-033 SHALL cover scenario 2: valid bits 28, 0 and 5 in one cycle, rr_ptr=6 -> reports in order 128, 100, 105 (wrap-around).
REQ-034 SHALL cover scenario 3: out_ready=0 for 10 cycles with index 107 offered -> out_index stable at 107; valid[7] re-hit during the wait -> exactly 2 reports of 107 without COVER_DEDUP_EN, 1 report with it.
REQ-035 SHALL cover scenario 4: 4 pending hits, then flush pulse -> flush_done pulses once, in the cycle the 4th handshake has drained and pending_cnt=0.
REQ-036 SHALL cover scenario 5: reset=0 for 1 cycle while out_valid=1 and pending_cnt=6 -> next cycle all outputs 0, state IDLE, no further reports.
REQ-037 SHALL cover scenario 6: enable=0 with valid=all ones -> pending_cnt stays 0 and out_valid never asserts.
